// File: rtl/spi_sclk_gen.sv
// rtl/spi_sclk_gen.sv - SPI SCLK/CSN sequencer with sample/shift strobes
// Divides i_clk_mhz into SCLK half-periods and frames i_cycles SCLK periods under CSN.
module spi_sclk_gen #(
   parameter int   par_clk_divisor = 8,
   parameter logic par_cpol        = 1'b0,
   parameter int   par_lead_ticks  = 2
) (
   input  logic       i_clk_mhz,
   input  logic       i_rstn_mhz,
   input  logic       i_start,
   input  logic [7:0] i_cycles,
   input  logic       i_abort,
   output logic       o_ready,
   output logic       o_csn,
   output logic       o_sclk,
   output logic       o_sample_ce,
   output logic       o_shift_ce,
   output logic       o_done
);

   localparam int H  = par_clk_divisor / 2;
   localparam int CW = (H > 1) ? $clog2(H) : 1;
   localparam int LW = (par_lead_ticks > 1) ? $clog2(par_lead_ticks) : 1;

   typedef enum logic [2:0] {IDLE, SETUP, RUN, HOLD, DONE} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [LW-1:0] lead_cnt;
   logic [7:0]    remaining;
   logic          tick;
   logic          lead_last;

   assign tick      = (cnt == CW'(H - 1));
   assign lead_last = (lead_cnt == LW'(par_lead_ticks - 1));

   always_ff @(posedge i_clk_mhz) begin
      if (!i_rstn_mhz) begin
         state       <= IDLE;
         cnt         <= '0;
         lead_cnt    <= '0;
         remaining   <= '0;
         o_ready     <= 1'b1;
         o_csn       <= 1'b1;
         o_sclk      <= par_cpol;
         o_sample_ce <= 1'b0;
         o_shift_ce  <= 1'b0;
         o_done      <= 1'b0;
      end else begin
         o_sample_ce <= 1'b0;
         o_shift_ce  <= 1'b0;
         o_done      <= 1'b0;
         if (state != IDLE && i_abort) begin
            state    <= IDLE;
            cnt      <= '0;
            lead_cnt <= '0;
            o_ready  <= 1'b1;
            o_csn    <= 1'b1;
            o_sclk   <= par_cpol;
         end else begin
            case (state)
               IDLE: begin
                  if (i_start && !i_abort) begin
                     cnt      <= '0;
                     lead_cnt <= '0;
                     o_ready  <= 1'b0;
                     if (i_cycles != 8'd0) begin
                        remaining <= i_cycles;
                        state     <= SETUP;
                        o_csn     <= 1'b0;
                     end else begin
                        state  <= DONE;
                        o_done <= 1'b1;
                     end
                  end
               end
               SETUP: begin
                  if (tick) begin
                     cnt <= '0;
                     // The first leading edge is launched on the last lead tick, so RUN opens with SCLK active.
                     if (lead_last) begin
                        state       <= RUN;
                        lead_cnt    <= '0;
                        o_sclk      <= ~par_cpol;
                        o_sample_ce <= 1'b1;
                     end else begin
                        lead_cnt <= lead_cnt + 1'b1;
                     end
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               RUN: begin
                  if (tick) begin
                     cnt <= '0;
                     if (o_sclk != par_cpol) begin
                        o_sclk     <= par_cpol;
                        o_shift_ce <= 1'b1;
                        remaining  <= remaining - 8'd1;
                     end else if (remaining == 8'd0) begin
                        state <= HOLD;
                     end else begin
                        o_sclk      <= ~par_cpol;
                        o_sample_ce <= 1'b1;
                     end
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               HOLD: begin
                  if (tick) begin
                     cnt    <= '0;
                     state  <= DONE;
                     o_csn  <= 1'b1;
                     o_done <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               DONE: begin
                  state   <= IDLE;
                  cnt     <= '0;
                  o_ready <= 1'b1;
               end
               default: begin
                  state   <= IDLE;
                  cnt     <= '0;
                  o_ready <= 1'b1;
                  o_csn   <= 1'b1;
                  o_sclk  <= par_cpol;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_sclk_gen.sv
// tb/tb_spi_sclk_gen.sv - scoreboard bench for spi_sclk_gen
// Expected strobe/done cycles are queued at request time and popped by a negedge monitor.
module tb_spi_sclk_gen;
   localparam int H    = 4;
   localparam int LEAD = 2;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       start1 = 1'b0;
   logic [7:0] cycles = 8'd0;
   logic [7:0] cycles1 = 8'd0;
   logic       ready, csn, sclk, sample, shift, done;
   logic       ready1, csn1, sclk1, sample1, shift1, done1;

   int cyc = 0;
   int checks = 0;
   int errors = 0;
   int exp_sample[$];
   int exp_shift[$];
   int exp_done[$];

   spi_sclk_gen u0 (
      .i_clk_mhz(clk), .i_rstn_mhz(rstn), .i_start(start), .i_cycles(cycles),
      .i_abort(abort), .o_ready(ready), .o_csn(csn), .o_sclk(sclk),
      .o_sample_ce(sample), .o_shift_ce(shift), .o_done(done)
   );

   spi_sclk_gen #(.par_clk_divisor(8), .par_cpol(1'b1), .par_lead_ticks(2)) u1 (
      .i_clk_mhz(clk), .i_rstn_mhz(rstn), .i_start(start1), .i_cycles(cycles1),
      .i_abort(abort), .o_ready(ready1), .o_csn(csn1), .o_sclk(sclk1),
      .o_sample_ce(sample1), .o_shift_ce(shift1), .o_done(done1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      int t;
      if (sample) begin
         checks++;
         if (exp_sample.size() == 0) begin
            errors++; $display("FAIL sample_unexpected at cyc=%0d required none", cyc);
         end else begin
            t = exp_sample.pop_front();
            if (t !== cyc || sclk !== 1'b1) begin
               errors++; $display("FAIL sample_time got=%0d sclk=%b required=%0d sclk=1", cyc, sclk, t);
            end
         end
      end
      if (shift) begin
         checks++;
         if (exp_shift.size() == 0) begin
            errors++; $display("FAIL shift_unexpected at cyc=%0d required none", cyc);
         end else begin
            t = exp_shift.pop_front();
            if (t !== cyc || sclk !== 1'b0) begin
               errors++; $display("FAIL shift_time got=%0d sclk=%b required=%0d sclk=0", cyc, sclk, t);
            end
         end
      end
      if (done) begin
         checks++;
         if (exp_done.size() == 0) begin
            errors++; $display("FAIL done_unexpected at cyc=%0d required none", cyc);
         end else begin
            t = exp_done.pop_front();
            if (t !== cyc || csn !== 1'b1) begin
               errors++; $display("FAIL done_time got=%0d csn=%b required=%0d csn=1", cyc, csn, t);
            end
         end
      end
   end

   task automatic push_exp(input int t, input int n);
      if (n == 0) begin
         exp_done.push_back(t + 1);
      end else begin
         for (int i = 0; i < n; i++) begin
            exp_sample.push_back(t + H * LEAD + 1 + 2 * H * i);
            exp_shift.push_back(t + H * LEAD + 1 + 2 * H * i + H);
         end
         exp_done.push_back(t + H * (LEAD + 2 * n + 1) + 1);
      end
   endtask

   task automatic start0(input int n, output int t);
      @(negedge clk);
      start = 1'b1; cycles = 8'(n); t = cyc;
      push_exp(t, n);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset;
      rstn = 1'b0; start = 1'b1; cycles = 8'd5;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if ({ready, csn, sclk, sample, shift, done} !== 6'b110000 || sclk1 !== 1'b1) begin
            errors++;
            $display("FAIL reset_state got=%b sclk1=%b required=110000 sclk1=1",
                     {ready, csn, sclk, sample, shift, done}, sclk1);
         end
      end
      start = 1'b0; rstn = 1'b1;
   endtask

   task automatic test_single;
      int t;
      start0(1, t);
      for (int k = 1; k <= 22; k++) begin
         if (k > 1) @(negedge clk);
         checks++;
         if (csn !== ((k <= 20) ? 1'b0 : 1'b1)) begin
            errors++; $display("FAIL single_csn at T+%0d got=%b required=%b", k, csn, (k <= 20) ? 1'b0 : 1'b1);
         end
      end
      checks++;
      if (ready !== 1'b1 || exp_sample.size() + exp_shift.size() + exp_done.size() != 0) begin
         errors++; $display("FAIL single_end ready=%b pending=%0d required ready=1 pending=0",
                            ready, exp_sample.size() + exp_shift.size() + exp_done.size());
         exp_sample.delete(); exp_shift.delete(); exp_done.delete();
      end
   endtask

   task automatic test_eight;
      int t;
      start0(8, t);
      repeat (78) @(negedge clk);
      checks++;
      if (exp_sample.size() + exp_shift.size() + exp_done.size() != 0) begin
         errors++; $display("FAIL eight_pending got=%0d required=0", exp_sample.size() + exp_shift.size() + exp_done.size());
         exp_sample.delete(); exp_shift.delete(); exp_done.delete();
      end
   endtask

   task automatic test_zero;
      int t;
      start0(0, t);
      checks++;
      if (ready !== 1'b0 || csn !== 1'b1) begin
         errors++; $display("FAIL zero_t1 ready=%b csn=%b required ready=0 csn=1", ready, csn);
      end
      @(negedge clk);
      checks++;
      if (ready !== 1'b1 || csn !== 1'b1 || exp_done.size() != 0) begin
         errors++; $display("FAIL zero_t2 ready=%b csn=%b pending=%0d required 1 1 0", ready, csn, exp_done.size());
         exp_done.delete();
      end
   endtask

   task automatic test_abort;
      int t;
      start0(4, t);
      repeat (9) @(negedge clk);
      abort = 1'b1;
      checks++;
      if (exp_sample.size() != 3 || exp_shift.size() != 4) begin
         errors++; $display("FAIL abort_pre samples_left=%0d shifts_left=%0d required 3 4", exp_sample.size(), exp_shift.size());
      end
      exp_sample.delete(); exp_shift.delete(); exp_done.delete();
      @(negedge clk);
      abort = 1'b0;
      checks++;
      if (csn !== 1'b1 || sclk !== 1'b0 || ready !== 1'b1) begin
         errors++; $display("FAIL abort_state csn=%b sclk=%b ready=%b required 1 0 1", csn, sclk, ready);
      end
      repeat (30) @(negedge clk);
   endtask

   task automatic test_abort_start_idle;
      @(negedge clk);
      start = 1'b1; abort = 1'b1; cycles = 8'd3;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (ready !== 1'b1 || csn !== 1'b1) begin
            errors++; $display("FAIL abort_idle k=%0d ready=%b csn=%b required 1 1", k, ready, csn);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back;
      int t;
      @(negedge clk);
      start = 1'b1; cycles = 8'd2; t = cyc;
      push_exp(t, 2);
      push_exp(t + 30, 1);
      @(negedge clk);
      cycles = 8'd1;
      repeat (28) @(negedge clk);
      checks++;
      if (csn !== 1'b1) begin
         errors++; $display("FAIL b2b_gap1 csn=%b required=1", csn);
      end
      @(negedge clk);
      checks++;
      if (csn !== 1'b1 || ready !== 1'b1) begin
         errors++; $display("FAIL b2b_gap2 csn=%b ready=%b required 1 1", csn, ready);
      end
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (csn !== 1'b0) begin
         errors++; $display("FAIL b2b_second csn=%b required=0", csn);
      end
      repeat (23) @(negedge clk);
      checks++;
      if (exp_sample.size() + exp_shift.size() + exp_done.size() != 0) begin
         errors++; $display("FAIL b2b_pending got=%0d required=0", exp_sample.size() + exp_shift.size() + exp_done.size());
         exp_sample.delete(); exp_shift.delete(); exp_done.delete();
      end
   endtask

   task automatic test_max_cycles;
      int t;
      start0(255, t);
      repeat (2060) @(negedge clk);
      checks++;
      if (exp_sample.size() + exp_shift.size() + exp_done.size() != 0 || csn !== 1'b1 || ready !== 1'b1) begin
         errors++; $display("FAIL max_pending got=%0d csn=%b ready=%b required 0 1 1",
                            exp_sample.size() + exp_shift.size() + exp_done.size(), csn, ready);
         exp_sample.delete(); exp_shift.delete(); exp_done.delete();
      end
   endtask

   task automatic test_reset_mid_run;
      int t;
      start0(4, t);
      repeat (10) @(negedge clk);
      rstn = 1'b0; start = 1'b1; abort = 1'b1;
      checks++;
      if (exp_sample.size() != 3) begin
         errors++; $display("FAIL rst_pre samples_left=%0d required=3", exp_sample.size());
      end
      exp_sample.delete(); exp_shift.delete(); exp_done.delete();
      @(negedge clk);
      rstn = 1'b1; start = 1'b0; abort = 1'b0;
      checks++;
      if ({ready, csn, sclk, sample, shift, done} !== 6'b110000) begin
         errors++; $display("FAIL rst_mid got=%b required=110000", {ready, csn, sclk, sample, shift, done});
      end
      start0(1, t);
      repeat (22) @(negedge clk);
      checks++;
      if (exp_sample.size() + exp_shift.size() + exp_done.size() != 0) begin
         errors++; $display("FAIL rst_after pending=%0d required=0", exp_sample.size() + exp_shift.size() + exp_done.size());
         exp_sample.delete(); exp_shift.delete(); exp_done.delete();
      end
   endtask

   task automatic test_cpol1;
      int  t, ns, nsh, nd;
      logic prev;
      ns = 0; nsh = 0; nd = 0; prev = 1'b1;
      @(negedge clk);
      start1 = 1'b1; cycles1 = 8'd2; t = cyc;
      checks++;
      if (sclk1 !== 1'b1) begin
         errors++; $display("FAIL cpol_idle sclk1=%b required=1", sclk1);
      end
      for (int k = 1; k <= 32; k++) begin
         @(negedge clk);
         start1 = 1'b0;
         if (sample1) begin
            ns++;
            checks++;
            if (sclk1 !== 1'b0 || prev !== 1'b1) begin
               errors++; $display("FAIL cpol_sample_edge T+%0d sclk1=%b prev=%b required 0 1", k, sclk1, prev);
            end
         end
         if (shift1) begin
            nsh++;
            checks++;
            if (sclk1 !== 1'b1) begin
               errors++; $display("FAIL cpol_shift_edge T+%0d sclk1=%b required=1", k, sclk1);
            end
         end
         if (done1) begin
            nd++;
            checks++;
            if (cyc !== t + H * (LEAD + 5) + 1) begin
               errors++; $display("FAIL cpol_done_time got=%0d required=%0d", cyc, t + H * (LEAD + 5) + 1);
            end
         end
         prev = sclk1;
      end
      checks++;
      if (ns != 2 || nsh != 2 || nd != 1 || sclk1 !== 1'b1) begin
         errors++; $display("FAIL cpol_counts sample=%0d shift=%0d done=%0d sclk1=%b required 2 2 1 1", ns, nsh, nd, sclk1);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_eight();
      test_zero();
      test_abort();
      test_abort_start_idle();
      test_back_to_back();
      test_max_cycles();
      test_reset_mid_run();
      test_cpol1();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
